control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 161 ++++++++++++++++
 tb/tb_control_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Registered RV32I(M) instruction decoder producing datapath control fields.
// Define RV32M_EN to also decode the M extension (MUL..REMU); without it those encodings are NOPs.
module control_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  output logic [4:0]  alu_signal,
  output logic        reg_file_write,
  output logic [2:0]  main_mem_write,
  output logic [3:0]  main_mem_read,
  output logic [3:0]  branch_control,
  output logic [3:0]  immediate_select,
  output logic        oparand_1_select,
  output logic        oparand_2_select,
  output logic [1:0]  reg_write_select
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef struct packed {
    logic [4:0] alu;
    logic       rfw;
    logic [2:0] mw;
    logic [3:0] mr;
    logic [3:0] br;
    logic [3:0] imm;
    logic       op1;
    logic       op2;
    logic [1:0] rws;
  } ctrl_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;
  ctrl_t      ctrl_d;
  ctrl_t      ctrl_q;

  assign opcode = INSTRUCTION[6:0];
  assign funct3 = INSTRUCTION[14:12];
  assign funct7 = INSTRUCTION[31:25];
  // Register indices are not needed for control decode.
  assign unused_fields = ^{INSTRUCTION[24:15], INSTRUCTION[11:7]};

  always_comb begin
    ctrl_d = '0;
    unique case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          ctrl_d.alu = {2'b00, funct3};
          ctrl_d.rfw = 1'b1;
        end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          ctrl_d.alu = {2'b01, funct3};
          ctrl_d.rfw = 1'b1;
`ifdef RV32M_EN
        end else if (funct7 == F7_MEXT) begin
          ctrl_d.alu = {2'b10, funct3};
          ctrl_d.rfw = 1'b1;
`endif
        end
      end
      OPC_OP_IMM: begin
        // Shift-immediates carry shamt in the immediate and constrain funct7.
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          if (funct7 == F7_BASE || (funct3 == 3'b101 && funct7 == F7_ALT)) begin
            ctrl_d.alu = {1'b0, funct7 == F7_ALT, funct3};
            ctrl_d.rfw = 1'b1;
            ctrl_d.op2 = 1'b1;
            ctrl_d.imm = 4'b0110;
          end
        end else begin
          ctrl_d.alu = {2'b00, funct3};
          ctrl_d.rfw = 1'b1;
          ctrl_d.op2 = 1'b1;
          ctrl_d.imm = 4'b0001;
        end
      end
      OPC_LOAD: begin
        if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) begin
          ctrl_d.mr  = {1'b1, funct3};
          ctrl_d.rfw = 1'b1;
          ctrl_d.op2 = 1'b1;
          ctrl_d.imm = 4'b0001;
          ctrl_d.rws = 2'b01;
        end
      end
      OPC_STORE: begin
        if (funct3[2] == 1'b0 && funct3[1:0] != 2'b11) begin
          ctrl_d.mw  = {1'b1, funct3[1:0]};
          ctrl_d.op2 = 1'b1;
          ctrl_d.imm = 4'b0010;
        end
      end
      OPC_BRANCH: begin
        if (funct3 != 3'b010 && funct3 != 3'b011) begin
          ctrl_d.br  = {1'b1, funct3};
          ctrl_d.op1 = 1'b1;
          ctrl_d.op2 = 1'b1;
          ctrl_d.imm = 4'b0011;
        end
      end
      OPC_JAL: begin
        ctrl_d.br  = 4'b1010;
        ctrl_d.op1 = 1'b1;
        ctrl_d.op2 = 1'b1;
        ctrl_d.imm = 4'b0101;
        ctrl_d.rfw = 1'b1;
        ctrl_d.rws = 2'b10;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          ctrl_d.br  = 4'b1010;
          ctrl_d.op2 = 1'b1;
          ctrl_d.imm = 4'b0001;
          ctrl_d.rfw = 1'b1;
          ctrl_d.rws = 2'b10;
        end
      end
      OPC_LUI: begin
        ctrl_d.imm = 4'b0100;
        ctrl_d.rfw = 1'b1;
        ctrl_d.rws = 2'b11;
      end
      OPC_AUIPC: begin
        ctrl_d.imm = 4'b0100;
        ctrl_d.op1 = 1'b1;
        ctrl_d.op2 = 1'b1;
        ctrl_d.rfw = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) ctrl_q <= '0;
    else        ctrl_q <= ctrl_d;
  end

  assign alu_signal       = ctrl_q.alu;
  assign reg_file_write   = ctrl_q.rfw;
  assign main_mem_write   = ctrl_q.mw;
  assign main_mem_read    = ctrl_q.mr;
  assign branch_control   = ctrl_q.br;
  assign immediate_select = ctrl_q.imm;
  assign oparand_1_select = ctrl_q.op1;
  assign oparand_2_select = ctrl_q.op2;
  assign reg_write_select = ctrl_q.rws;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed vector table, reset sequences, and random
// instructions checked against a rule-level decode model.
module tb_control_unit;

`ifdef RV32M_EN
  localparam bit M_ON = 1'b1;
`else
  localparam bit M_ON = 1'b0;
`endif

  logic        CLK;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic [4:0]  alu_signal;
  logic        reg_file_write;
  logic [2:0]  main_mem_write;
  logic [3:0]  main_mem_read;
  logic [3:0]  branch_control;
  logic [3:0]  immediate_select;
  logic        oparand_1_select;
  logic        oparand_2_select;
  logic [1:0]  reg_write_select;

  int n_tests = 0;
  int n_fail  = 0;

  control_unit dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION),
    .alu_signal(alu_signal), .reg_file_write(reg_file_write),
    .main_mem_write(main_mem_write), .main_mem_read(main_mem_read),
    .branch_control(branch_control), .immediate_select(immediate_select),
    .oparand_1_select(oparand_1_select), .oparand_2_select(oparand_2_select),
    .reg_write_select(reg_write_select)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Packed order: alu, rfw, mw, mr, br, imm, op1, op2, rws
  function automatic logic [24:0] mk(input logic [4:0] alu, input logic rfw,
      input logic [2:0] mw, input logic [3:0] mr, input logic [3:0] br,
      input logic [3:0] imm, input logic op1, input logic op2, input logic [1:0] rws);
    return {alu, rfw, mw, mr, br, imm, op1, op2, rws};
  endfunction

  function automatic logic [24:0] outs();
    return {alu_signal, reg_file_write, main_mem_write, main_mem_read, branch_control,
            immediate_select, oparand_1_select, oparand_2_select, reg_write_select};
  endfunction

  // Reference decode written from the instruction-set rules.
  function automatic logic [24:0] model(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    if (op == 7'h33) begin
      if (f7 == 7'h00)                              return mk({2'b00, f3}, 1, 0, 0, 0, 0, 0, 0, 0);
      if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) return mk({2'b01, f3}, 1, 0, 0, 0, 0, 0, 0, 0);
      if (f7 == 7'h01 && M_ON)                      return mk({2'b10, f3}, 1, 0, 0, 0, 0, 0, 0, 0);
      return '0;
    end
    if (op == 7'h13) begin
      if (f3 == 3'd1) return (f7 == 7'h00) ? mk({2'b00, f3}, 1, 0, 0, 0, 4'd6, 0, 1, 0) : '0;
      if (f3 == 3'd5) begin
        if (f7 == 7'h00) return mk(5'b00101, 1, 0, 0, 0, 4'd6, 0, 1, 0);
        if (f7 == 7'h20) return mk(5'b01101, 1, 0, 0, 0, 4'd6, 0, 1, 0);
        return '0;
      end
      return mk({2'b00, f3}, 1, 0, 0, 0, 4'd1, 0, 1, 0);
    end
    if (op == 7'h03) return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ?
                            mk(0, 1, 0, {1'b1, f3}, 0, 4'd1, 0, 1, 2'b01) : '0;
    if (op == 7'h23) return (f3 <= 3'd2) ? mk(0, 0, {1'b1, f3[1:0]}, 0, 0, 4'd2, 0, 1, 0) : '0;
    if (op == 7'h63) return (f3 == 3'd2 || f3 == 3'd3) ? '0 :
                            mk(0, 0, 0, 0, {1'b1, f3}, 4'd3, 1, 1, 0);
    if (op == 7'h6F) return mk(0, 1, 0, 0, 4'b1010, 4'd5, 1, 1, 2'b10);
    if (op == 7'h67) return (f3 == 3'd0) ? mk(0, 1, 0, 0, 4'b1010, 4'd1, 0, 1, 2'b10) : '0;
    if (op == 7'h37) return mk(0, 1, 0, 0, 0, 4'd4, 0, 0, 2'b11);
    if (op == 7'h17) return mk(0, 1, 0, 0, 0, 4'd4, 1, 1, 0);
    return '0;
  endfunction

  task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %025b expected %025b", name, act, exp);
    end
  endtask

  task automatic apply(input logic [31:0] w);
    @(negedge CLK);
    INSTRUCTION = w;
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [24:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   picks[11];

  initial begin
    vecs.push_back('{"add",     32'h002081B3, mk(0, 1, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"lw",      32'h00812283, mk(0, 1, 0, 4'b1010, 0, 4'b0001, 0, 1, 2'b01)});
    vecs.push_back('{"sw",      32'h00512623, mk(0, 0, 3'b110, 0, 0, 4'b0010, 0, 1, 0)});
    vecs.push_back('{"beq",     32'h00208463, mk(0, 0, 0, 0, 4'b1000, 4'b0011, 1, 1, 0)});
    vecs.push_back('{"mul",     32'h022081B3, M_ON ? mk(5'b10000, 1, 0, 0, 0, 0, 0, 0, 0) : 25'd0});
    vecs.push_back('{"all_ones", 32'hFFFFFFFF, 25'd0});
    vecs.push_back('{"jal",     32'h008000EF, mk(0, 1, 0, 0, 4'b1010, 4'b0101, 1, 1, 2'b10)});
    vecs.push_back('{"sub",     32'h402081B3, mk(5'b01000, 1, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"bad_alt", 32'h402091B3, 25'd0});
    vecs.push_back('{"srai",    32'h4030D093, mk(5'b01101, 1, 0, 0, 0, 4'b0110, 0, 1, 0)});
    vecs.push_back('{"lui",     32'h000012B7, mk(0, 1, 0, 0, 0, 4'b0100, 0, 0, 2'b11)});
    vecs.push_back('{"auipc",   32'h00000297, mk(0, 1, 0, 0, 0, 4'b0100, 1, 1, 0)});
    vecs.push_back('{"jalr",    32'h000100E7, mk(0, 1, 0, 0, 4'b1010, 4'b0001, 0, 1, 2'b10)});
    vecs.push_back('{"fence",   32'h0000000F, 25'd0});
    vecs.push_back('{"ecall",   32'h00000073, 25'd0});
    vecs.push_back('{"bad_br",  32'h0020A463, 25'd0});

    RESET = 1'b0;
    INSTRUCTION = 32'h002081B3;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_hold", outs(), 25'd0);

    @(negedge CLK);
    #2 RESET = 1'b1;
    @(posedge CLK);
    #1;
    check("first_after_reset", outs(), mk(0, 1, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      apply(vecs[i].ins);
      check(vecs[i].name, outs(), vecs[i].exp);
    end

    // Mid-stream reset: outputs must clear without a clock edge.
    apply(32'h00812283);
    check("pre_async", outs(), mk(0, 1, 0, 4'b1010, 0, 4'b0001, 0, 1, 2'b01));
    #2 RESET = 1'b0;
    #1;
    check("async_clear", outs(), 25'd0);
    @(negedge CLK);
    INSTRUCTION = 32'h00208463;
    @(posedge CLK);
    #1;
    check("held_in_reset", outs(), 25'd0);
    @(negedge CLK);
    #2 RESET = 1'b1;
    @(posedge CLK);
    #1;
    check("release_decode", outs(), mk(0, 0, 0, 0, 4'b1000, 4'b0011, 1, 1, 0));

    picks = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};
    for (int k = 0; k < 400; k++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 9) != 0) w[6:0] = 7'(picks[$urandom_range(0, 10)]);
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
      apply(w);
      check($sformatf("rand_%08h", w), outs(), model(w));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
